// File: rtl/tx_stream_ctrl.sv
// Host command/stream controller: parses FT245 byte packets into config writes, FIFO
// samples and START/STOP, and sequences the modulator. Optional status readback: TX_STATUS_EN.
module tx_stream_ctrl #(
    parameter int DEPTH_WIDTH = 10,
    parameter int PREFILL     = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_si,
    input  logic       rx_valid_si,
    output logic       rx_ready_si,
    output logic [7:0] tx_data_si,
    output logic       tx_valid_si,
    input  logic       tx_ready_si,
    output logic [7:0] fifo_wr_data,
    output logic       fifo_wr_en,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic       mod_read,
    output logic       mod_enable,
    output logic [7:0] cfg_reg0,
    output logic [7:0] cfg_reg1,
    output logic [7:0] cfg_reg2,
    output logic [7:0] cfg_reg3,
    output logic       underflow,
    output logic [7:0] underflow_cnt
);

    localparam logic [DEPTH_WIDTH:0] LP_PREFILL = PREFILL[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] LP_OCC_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        P_IDLE, P_CFG_ADDR, P_CFG_VAL, P_LEN, P_PAYLOAD, P_STAT0, P_STAT1
    } parse_t;

    // Encoding is visible to the host through the status byte.
    typedef enum logic [1:0] {
        R_STOPPED = 2'd0, R_PREFILL = 2'd1, R_RUN = 2'd2, R_DRAIN = 2'd3
    } run_t;

    parse_t               r_pstate, w_pnext;
    run_t                 r_rstate, w_rnext;
    logic [1:0]           r_addr;
    logic [8:0]           r_remain;
    logic [7:0]           r_cfg [4];
    logic [DEPTH_WIDTH:0] r_occ;
    logic                 r_mod_enable;
    logic                 r_underflow;
    logic [7:0]           r_ucnt;

    logic                 w_rx_ready;
    logic                 w_accept;
    logic                 w_wr_en;
    logic                 w_rd;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_tx_valid;
    logic [7:0]           w_tx_data;

    // Ready is kept apart from the next-state logic so accept has no loop through it.
    always_comb begin
        w_rx_ready = 1'b0;
        if (!rst) begin
            case (r_pstate)
                P_IDLE, P_CFG_ADDR, P_CFG_VAL, P_LEN: w_rx_ready = 1'b1;
                P_PAYLOAD:                            w_rx_ready = !fifo_full;
                default:                              w_rx_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = rx_valid_si & w_rx_ready;
    assign w_wr_en  = w_accept && (r_pstate == P_PAYLOAD);
    assign w_rd     = mod_read & !fifo_empty;

    always_comb begin
        w_pnext    = r_pstate;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'd0;
        case (r_pstate)
            P_IDLE: begin
                if (w_accept) begin
                    case (rx_data_si)
                        8'h01:   w_pnext = P_CFG_ADDR;
                        8'h02:   w_pnext = P_LEN;
                        8'h03:   w_start = 1'b1;
                        8'h04:   w_stop  = 1'b1;
`ifdef TX_STATUS_EN
                        8'h05:   w_pnext = P_STAT0;
`endif
                        default: w_pnext = P_IDLE;
                    endcase
                end
            end
            P_CFG_ADDR: if (w_accept) w_pnext = P_CFG_VAL;
            P_CFG_VAL:  if (w_accept) w_pnext = P_IDLE;
            P_LEN:      if (w_accept) w_pnext = P_PAYLOAD;
            P_PAYLOAD:  if (w_accept && r_remain == 9'd1) w_pnext = P_IDLE;
`ifdef TX_STATUS_EN
            P_STAT0: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {r_rstate, r_underflow, fifo_full, fifo_empty, 3'b000};
                if (tx_ready_si) w_pnext = P_STAT1;
            end
            P_STAT1: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_ucnt;
                if (tx_ready_si) w_pnext = P_IDLE;
            end
`endif
            default: w_pnext = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pstate <= P_IDLE;
            r_remain <= 9'd0;
        end else begin
            r_pstate <= w_pnext;
            if (w_accept && r_pstate == P_LEN)
                r_remain <= (rx_data_si == 8'd0) ? 9'd256 : {1'b0, rx_data_si};
            else if (w_wr_en)
                r_remain <= r_remain - 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && r_pstate == P_CFG_ADDR)
            r_addr <= rx_data_si[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_cfg[i] <= 8'd0;
        end else if (w_accept && r_pstate == P_CFG_VAL) begin
            r_cfg[r_addr] <= rx_data_si;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_wr_en, w_rd})
                2'b10:   r_occ <= r_occ + LP_OCC_ONE;
                2'b01:   r_occ <= r_occ - LP_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_STOPPED: if (w_start) w_rnext = R_PREFILL;
            R_PREFILL: begin
                if (w_stop)
                    w_rnext = R_STOPPED;
                else if (r_occ >= LP_PREFILL || fifo_full)
                    w_rnext = R_RUN;
            end
            R_RUN:     if (w_stop) w_rnext = R_DRAIN;
            R_DRAIN:   if (fifo_empty) w_rnext = R_STOPPED;
            default:   w_rnext = R_STOPPED;
        endcase
    end

    // Enable is registered from the next state so it rises on the edge RUN is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate     <= R_STOPPED;
            r_mod_enable <= 1'b0;
        end else begin
            r_rstate     <= w_rnext;
            r_mod_enable <= (w_rnext == R_RUN) || (w_rnext == R_DRAIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_ucnt      <= 8'd0;
        end else if (r_rstate == R_RUN && mod_read && fifo_empty) begin
            r_underflow <= 1'b1;
            if (r_ucnt != 8'hFF) r_ucnt <= r_ucnt + 8'd1;
        end
    end

`ifndef TX_STATUS_EN
    logic w_unused_tx_ready;
    assign w_unused_tx_ready = tx_ready_si;
`endif

    assign rx_ready_si   = w_rx_ready;
    assign tx_valid_si   = w_tx_valid;
    assign tx_data_si    = w_tx_data;
    assign fifo_wr_data  = rx_data_si;
    assign fifo_wr_en    = w_wr_en;
    assign mod_enable    = r_mod_enable;
    assign cfg_reg0      = r_cfg[0];
    assign cfg_reg1      = r_cfg[1];
    assign cfg_reg2      = r_cfg[2];
    assign cfg_reg3      = r_cfg[3];
    assign underflow     = r_underflow;
    assign underflow_cnt = r_ucnt;

endmodule

// File: tb/tb_tx_stream_ctrl.sv
// Scoreboard bench for tx_stream_ctrl: FIFO writes are checked by a monitor against a
// queue of expected samples; control/status outputs are checked directly.
module tb_tx_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data_si;
    logic       rx_valid_si;
    logic       rx_ready_si;
    logic [7:0] tx_data_si;
    logic       tx_valid_si;
    logic       tx_ready_si;
    logic [7:0] fifo_wr_data;
    logic       fifo_wr_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic       mod_read;
    logic       mod_enable;
    logic [7:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
    logic       underflow;
    logic [7:0] underflow_cnt;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q [$];
    int         m_occ;

    always #5 clk = ~clk;

    tx_stream_ctrl #(.DEPTH_WIDTH(10), .PREFILL(512)) dut (
        .clk(clk), .rst(rst),
        .rx_data_si(rx_data_si), .rx_valid_si(rx_valid_si), .rx_ready_si(rx_ready_si),
        .tx_data_si(tx_data_si), .tx_valid_si(tx_valid_si), .tx_ready_si(tx_ready_si),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .mod_read(mod_read), .mod_enable(mod_enable),
        .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3),
        .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    // Behavioural FIFO occupancy; full is forced by the stimulus when needed.
    assign fifo_empty = (m_occ == 0);
    always @(posedge clk) begin
        if (rst) m_occ <= 0;
        else     m_occ <= m_occ + (fifo_wr_en ? 1 : 0) - ((mod_read && m_occ > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (!rst && fifo_wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fifo_wr: unexpected write of %02h, nothing expected", fifo_wr_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (fifo_wr_data !== e) begin
                    n_err++;
                    $display("FAIL fifo_wr: got %02h expected %02h", fifo_wr_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        rx_data_si  = b;
        rx_valid_si = 1'b1;
        t = 0;
        #1;
        while (!rx_ready_si && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready_si) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: byte %02h not accepted, ready=%0b required 1", b, rx_ready_si);
        end
        @(posedge clk);
        #1;
        rx_valid_si = 1'b0;
    endtask

    task automatic reads(input int n);
        mod_read = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        mod_read = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_valid_si = 1'b0; rx_data_si = 8'd0;
        tx_ready_si = 1'b0; fifo_full = 1'b0; mod_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_ready", rx_ready_si, 0);
        chk("reset_mod_enable", mod_enable, 0);
        chk("reset_cfg", {cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3}, 0);
        chk("reset_underflow", underflow, 0);
        chk("reset_ucnt", underflow_cnt, 0);
        chk("reset_tx_valid", tx_valid_si, 0);
        chk("reset_tx_data", tx_data_si, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_rx_ready", rx_ready_si, 1);

        send(8'h01); send(8'h02); send(8'h37);
        chk("cfg2_write", cfg_reg2, 8'h37);
        chk("cfg_others_zero", {cfg_reg0, cfg_reg1, cfg_reg3}, 0);

        // Unknown opcode dropped; address upper bits ignored (0x05 -> reg1).
        send(8'hFF); send(8'h01); send(8'h05); send(8'h22);
        chk("cfg1_addr_mask", cfg_reg1, 8'h22);

        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
        send(8'h02); send(8'h03); send(8'hAA);
        rx_data_si = 8'hBB; rx_valid_si = 1'b1; fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready_low", rx_ready_si, 0);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        #1;
        chk("stall_release_ready", rx_ready_si, 1);
        @(posedge clk); #1;
        rx_valid_si = 1'b0;
        send(8'hCC);
        chk("payload_all_written", exp_q.size(), 0);
        chk("after_payload_idle_ready", rx_ready_si, 1);

        reads(3);
        send(8'h03);
        chk("prefill_enable_low", mod_enable, 0);
        for (int blk = 0; blk < 2; blk++) begin
            send(8'h02); send(8'h00);
            for (int i = 0; i < 256; i++) begin
                exp_q.push_back(8'(i + blk));
                send(8'(i + blk));
                if (blk == 1 && i == 254) chk("enable_low_at_511", mod_enable, 0);
            end
        end
        chk("enable_low_at_512_edge", mod_enable, 0);
        @(posedge clk); #1;
        chk("enable_high_after_512", mod_enable, 1);

        reads(502);
        send(8'h04);
        chk("drain_enable_held", mod_enable, 1);
        mod_read = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_enable_until_empty", mod_enable, 1);
        @(posedge clk); #1;
        mod_read = 1'b0;
        chk("drain_enable_off", mod_enable, 0);
        chk("drain_no_underflow", underflow, 0);
        chk("drain_ucnt_zero", underflow_cnt, 0);

        send(8'h03);
        fifo_full = 1'b1;
        @(posedge clk); #1;
        fifo_full = 1'b0;
        chk("run_via_full", mod_enable, 1);
        chk("run_no_underflow_yet", underflow, 0);
        reads(3);
        chk("underflow_flag", underflow, 1);
        chk("underflow_cnt3", underflow_cnt, 3);

`ifdef TX_STATUS_EN
        send(8'h05);
        @(posedge clk); #1;
        chk("stat0_valid", tx_valid_si, 1);
        chk("stat0_data", tx_data_si, 8'hA8);
        chk("stat_rx_stalled", rx_ready_si, 0);
        tx_ready_si = 1'b1;
        @(posedge clk); #1;
        chk("stat1_valid", tx_valid_si, 1);
        chk("stat1_data", tx_data_si, 8'h03);
        @(posedge clk); #1;
        tx_ready_si = 1'b0;
        chk("stat_done_valid", tx_valid_si, 0);
        chk("stat_done_ready", rx_ready_si, 1);
`else
        send(8'h05);
        chk("op05_no_tx_valid", tx_valid_si, 0);
        send(8'h01); send(8'h00); send(8'h77);
        chk("op05_dropped_cfg0", cfg_reg0, 8'h77);
`endif

        reads(297);
        chk("underflow_cnt_sat", underflow_cnt, 8'hFF);
        chk("underflow_sticky", underflow, 1);

        exp_q.push_back(8'hAA);
        send(8'h02); send(8'h05); send(8'hAA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_cfg2_cleared", cfg_reg2, 0);
        chk("midrst_underflow", underflow, 0);
        chk("midrst_ucnt", underflow_cnt, 0);
        chk("midrst_enable", mod_enable, 0);
        send(8'h01); send(8'h03); send(8'h5A);
        chk("midrst_opcode_parsed", cfg_reg3, 8'h5A);
        @(posedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
